// File: rtl/jump_encoder.sv
// jump_encoder: packs a 32-bit byte jump target into a MIPS J/JAL word.
// Two-stage valid/ready pipeline: stage 1 captures the request and its
// alignment flag, stage 2 forms the instruction word and the region flag.
// err_cnt counts delivered words carrying any error flag, saturating at 8'hFF.
// Optional feature macro: JENC_REGION_CHECK_EN (enables the 256 MB region check).
module jump_encoder #(
    parameter logic [5:0] OPC_J   = 6'b000010,
    parameter logic [5:0] OPC_JAL = 6'b000011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_target,
    input  logic        in_link,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err_align,
    output logic        out_err_region,
    output logic [7:0]  err_cnt
);
    logic        s2_adv;
    logic        s1_adv;

    logic        s1_valid_q,  s1_valid_d;
    logic [25:0] s1_word_q,   s1_word_d;
    logic        s1_link_q,   s1_link_d;
    logic        s1_align_q,  s1_align_d;

    logic        out_valid_q,      out_valid_d;
    logic [31:0] out_instr_q,      out_instr_d;
    logic        out_err_align_q,  out_err_align_d;
    logic        out_err_region_q, out_err_region_d;
    logic [7:0]  err_cnt_q,        err_cnt_d;

    logic        region_err;

`ifdef JENC_REGION_CHECK_EN
    logic [3:0]  s1_pc_hi_q,  s1_pc_hi_d;
    logic [3:0]  s1_tgt_hi_q, s1_tgt_hi_d;
    logic [3:0]  pc_hi;
    logic [27:0] pc_low_unused;

    // The region is that of the delay-slot address; the add wraps mod 2^32.
    assign {pc_hi, pc_low_unused} = in_pc + 32'd4;
    assign region_err = (s1_tgt_hi_q != s1_pc_hi_q);

    // Capture the region nibbles alongside the rest of stage 1.
    always_comb begin
        s1_pc_hi_d  = s1_pc_hi_q;
        s1_tgt_hi_d = s1_tgt_hi_q;
        if (s1_adv && in_valid) begin
            s1_pc_hi_d  = pc_hi;
            s1_tgt_hi_d = in_target[31:28];
        end
    end

    // Region nibble registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_pc_hi_q  <= 4'h0;
            s1_tgt_hi_q <= 4'h0;
        end else begin
            s1_pc_hi_q  <= s1_pc_hi_d;
            s1_tgt_hi_q <= s1_tgt_hi_d;
        end
    end
`else
    // Without the region check the pc and the target's top nibble play no part.
    logic unused_region_inputs;
    assign unused_region_inputs = ^{in_pc, in_target[31:28]};
    assign region_err = 1'b0;
`endif

    assign s2_adv   = ~out_valid_q | out_ready;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign in_ready = s1_adv;

    // Stage 1: accept a request whenever the stage can move forward.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_word_d  = s1_word_q;
        s1_link_d  = s1_link_q;
        s1_align_d = s1_align_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_word_d  = in_target[27:2];
                s1_link_d  = in_link;
                s1_align_d = (in_target[1:0] != 2'b00);
            end
        end
    end

    // Stage 2: form the word (packed even when flagged) and count delivered errors.
    always_comb begin
        out_valid_d      = out_valid_q;
        out_instr_d      = out_instr_q;
        out_err_align_d  = out_err_align_q;
        out_err_region_d = out_err_region_q;
        err_cnt_d        = err_cnt_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_instr_d      = {(s1_link_q ? OPC_JAL : OPC_J), s1_word_q};
                out_err_align_d  = s1_align_q;
                out_err_region_d = region_err;
            end
        end
        if (out_valid_q && out_ready && (out_err_align_q || out_err_region_q)
                && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Pipeline and counter registers; reset drops any in-flight words.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q       <= 1'b0;
            s1_word_q        <= 26'h0;
            s1_link_q        <= 1'b0;
            s1_align_q       <= 1'b0;
            out_valid_q      <= 1'b0;
            out_instr_q      <= 32'h0;
            out_err_align_q  <= 1'b0;
            out_err_region_q <= 1'b0;
            err_cnt_q        <= 8'h00;
        end else begin
            s1_valid_q       <= s1_valid_d;
            s1_word_q        <= s1_word_d;
            s1_link_q        <= s1_link_d;
            s1_align_q       <= s1_align_d;
            out_valid_q      <= out_valid_d;
            out_instr_q      <= out_instr_d;
            out_err_align_q  <= out_err_align_d;
            out_err_region_q <= out_err_region_d;
            err_cnt_q        <= err_cnt_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_instr      = out_instr_q;
    assign out_err_align  = out_err_align_q;
    assign out_err_region = out_err_region_q;
    assign err_cnt        = err_cnt_q;

endmodule
